// File: rtl/mips_decode_stage.sv
// -----------------------------------------------------------------------------
// mips_decode_stage
//   Registered MIPS instruction-decode stage. Splits the instruction into its
//   fields, extends the immediate, classifies the encoding and counts illegal
//   instructions. A two-entry buffer (output register + skid register) lets
//   the stage absorb one cycle of downstream back-pressure without dropping
//   an instruction, and keeps in_ready a pure register output.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               squash every buffered instruction
//   in_valid/in_ready   fetch-side handshake (in_ready = skid empty)
//   in_instr, in_pc     instruction word and its PC
//   out_valid/out_ready decode-side handshake
//   out_opcode .. out_jtarget  decoded fields, unused ones driven 0
//   out_class           0 R, 1 I-ALU, 2 branch, 3 load, 4 store, 5 jump, 7 ill
//   out_illegal         unsupported opcode or R-type funct
//   out_pc              PC travelling with the bundle
//   ill_count           saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module mips_decode_stage #(
    parameter int DATA_W           = 32,
    parameter int PC_W             = 32,
    parameter int ZERO_EXT_LOGICAL = 1,
    parameter int ILL_CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_W-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_opcode,
    output logic [4:0]           out_rs,
    output logic [4:0]           out_rt,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_shamt,
    output logic [5:0]           out_funct,
    output logic [DATA_W-1:0]    out_imm_ext,
    output logic [25:0]          out_jtarget,
    output logic [2:0]           out_class,
    output logic                 out_illegal,
    output logic [PC_W-1:0]      out_pc,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_IALU   = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_JUMP   = 3'd5,
        CLS_ILL    = 3'd7
    } cls_e;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm_ext;
        logic [25:0]       jtarget;
        cls_e              cls;
        logic              illegal;
        logic [PC_W-1:0]   pc;
    } bundle_t;

    bundle_t              w_dec;
    cls_e                 w_cls;
    logic                 w_zext;
    logic                 w_in_fire;
    logic                 w_out_fire;

    bundle_t              r_out;
    bundle_t              r_skid;
    logic                 r_out_valid;
    logic                 r_skid_valid;
    logic [ILL_CNT_W-1:0] r_ill_count;

    // Decode happens on the way in, so both buffer entries hold finished
    // bundles and the outputs come straight from flops.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can leave it unassigned (no latch).
        w_cls  = CLS_ILL;
        w_zext = 1'b0;
        unique case (in_instr[31:26])
            6'd0: begin
                unique case (in_instr[5:0])
                    6'h00, 6'h08, 6'h20, 6'h22,
                    6'h24, 6'h25, 6'h27, 6'h2A: w_cls = CLS_R;
                    default:                    w_cls = CLS_ILL;
                endcase
            end
            6'd2, 6'd3:   w_cls = CLS_JUMP;
            6'd4, 6'd5:   w_cls = CLS_BRANCH;
            6'd8, 6'd10:  w_cls = CLS_IALU;
            6'd12, 6'd13: begin
                w_cls  = CLS_IALU;
                w_zext = (ZERO_EXT_LOGICAL != 0);
            end
            6'd35:        w_cls = CLS_LOAD;
            6'd43:        w_cls = CLS_STORE;
            default:      w_cls = CLS_ILL;
        endcase

        w_dec         = '0;
        w_dec.opcode  = in_instr[31:26];
        w_dec.rs      = in_instr[25:21];
        w_dec.rt      = in_instr[20:16];
        w_dec.rd      = in_instr[15:11];
        w_dec.shamt   = in_instr[10:6];
        w_dec.funct   = in_instr[5:0];
        // Fill the upper bits first, then overlay the 16-bit field; this
        // stays legal when DATA_W is exactly 16.
        w_dec.imm_ext = w_zext ? '0 : {DATA_W{in_instr[15]}};
        w_dec.imm_ext[15:0] = in_instr[15:0];
        w_dec.jtarget = in_instr[25:0];
        w_dec.cls     = w_cls;
        w_dec.illegal = (w_cls == CLS_ILL);
        w_dec.pc      = in_pc;

        // Fields the class does not use are forced to zero; illegal keeps raw bits.
        unique case (w_cls)
            CLS_R: begin
                w_dec.imm_ext = '0;
                w_dec.jtarget = '0;
            end
            CLS_IALU, CLS_BRANCH, CLS_LOAD, CLS_STORE: begin
                w_dec.rd      = '0;
                w_dec.shamt   = '0;
                w_dec.funct   = '0;
                w_dec.jtarget = '0;
            end
            CLS_JUMP: begin
                w_dec.rs      = '0;
                w_dec.rt      = '0;
                w_dec.rd      = '0;
                w_dec.shamt   = '0;
                w_dec.funct   = '0;
                w_dec.imm_ext = '0;
            end
            default: ;
        endcase
    end

    assign in_ready   = ~r_skid_valid;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the buffer entries are reset too, because the data outputs
            // must read 0 after reset and they are driven directly by r_out.
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ill_count  <= '0;
        end else begin
            // Counting is independent of flush: a squashed illegal still counts.
            if (w_in_fire && w_dec.illegal && (r_ill_count != '1)) begin
                r_ill_count <= r_ill_count + 1'b1;
            end

            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_fire || !r_out_valid) begin
                // Output slot frees up: the older skid entry has priority.
                // in_ready is low while the skid is full, so no input collides.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_opcode  = r_out.opcode;
    assign out_rs      = r_out.rs;
    assign out_rt      = r_out.rt;
    assign out_rd      = r_out.rd;
    assign out_shamt   = r_out.shamt;
    assign out_funct   = r_out.funct;
    assign out_imm_ext = r_out.imm_ext;
    assign out_jtarget = r_out.jtarget;
    assign out_class   = r_out.cls;
    assign out_illegal = r_out.illegal;
    assign out_pc      = r_out.pc;
    assign ill_count   = r_ill_count;

endmodule

// File: tb/tb_mips_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_mips_decode_stage
//   Directed bench for mips_decode_stage. Two instances share the stimulus:
//   u_dut uses the defaults, u_alt uses ZERO_EXT_LOGICAL=0 and ILL_CNT_W=2 so
//   the alternate immediate extension and counter saturation are visible.
// -----------------------------------------------------------------------------
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_imm_ext;
    logic [25:0] out_jtarget;
    logic [2:0]  out_class;
    logic        out_illegal;
    logic [31:0] out_pc;
    logic [7:0]  ill_count;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
    logic [31:0] b_imm_ext, b_pc;
    logic [25:0] b_jtarget;
    logic [2:0]  b_class;
    logic [1:0]  b_ill_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mips_decode_stage u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
        .out_imm_ext(out_imm_ext), .out_jtarget(out_jtarget),
        .out_class(out_class), .out_illegal(out_illegal),
        .out_pc(out_pc), .ill_count(ill_count)
    );

    mips_decode_stage #(.ZERO_EXT_LOGICAL(0), .ILL_CNT_W(2)) u_alt (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_opcode(b_opcode), .out_rs(b_rs), .out_rt(b_rt),
        .out_rd(b_rd), .out_shamt(b_shamt), .out_funct(b_funct),
        .out_imm_ext(b_imm_ext), .out_jtarget(b_jtarget),
        .out_class(b_class), .out_illegal(b_out_illegal),
        .out_pc(b_pc), .ill_count(b_ill_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] I_ADD  = 32'h0109_5020;
    localparam logic [31:0] I_ADDI = 32'h2008_FFFF;
    localparam logic [31:0] I_JAL  = 32'h0C10_0000;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ill", ill_count, 0);
        check("rst_imm", out_imm_ext, 0);
        check("rst_pc", out_pc, 0);

        // addi $t0,$0,-1
        send(I_ADDI, 32'h400);
        check("addi_valid", out_valid, 1);
        check("addi_class", out_class, 1);
        check("addi_rs", out_rs, 0);
        check("addi_rt", out_rt, 8);
        check("addi_imm", out_imm_ext, 32'hFFFF_FFFF);
        check("addi_rd", out_rd, 0);
        check("addi_pc", out_pc, 32'h400);
        check("addi_ill", out_illegal, 0);

        // andi: zero-extended by default, sign-extended in the alternate build
        send(32'h3108_FFFF, 32'h404);
        check("andi_class", out_class, 1);
        check("andi_rs", out_rs, 8);
        check("andi_imm", out_imm_ext, 32'h0000_FFFF);
        check("andi_imm_alt", b_imm_ext, 32'hFFFF_FFFF);

        // add $t2,$t0,$t1
        send(I_ADD, 32'h408);
        check("add_class", out_class, 0);
        check("add_rs", out_rs, 8);
        check("add_rt", out_rt, 9);
        check("add_rd", out_rd, 10);
        check("add_funct", out_funct, 6'h20);
        check("add_imm", out_imm_ext, 0);
        check("add_jt", out_jtarget, 0);

        // jal
        send(I_JAL, 32'h40C);
        check("jal_class", out_class, 5);
        check("jal_jt", out_jtarget, 26'h010_0000);
        check("jal_rs", out_rs, 0);
        check("jal_rt", out_rt, 0);
        check("jal_imm", out_imm_ext, 0);
        check("legal_ill_cnt", ill_count, 0);

        // Illegal opcode and illegal R-type funct
        send(32'hFC00_0000, 32'h410);
        check("ill1_flag", out_illegal, 1);
        check("ill1_class", out_class, 7);
        check("ill1_cnt", ill_count, 1);
        send(32'h0000_0001, 32'h414);
        check("ill2_flag", out_illegal, 1);
        check("ill2_class", out_class, 7);
        check("ill2_funct", out_funct, 1);
        check("ill2_cnt", ill_count, 2);
        check("ill2_cnt_alt", b_ill_count, 2);

        // Illegal carries raw fields with a sign-extended immediate
        send(32'h0400_8001, 32'h418);
        check("ill3_imm", out_imm_ext, 32'hFFFF_8001);
        check("ill3_rd", out_rd, 16);
        check("ill3_funct", out_funct, 1);
        send(32'hFC00_0000, 32'h41C);
        send(32'h0000_0001, 32'h420);
        check("ill5_cnt", ill_count, 5);
        check("ill5_sat_alt", b_ill_count, 3);

        step();
        check("drain_valid", out_valid, 0);

        // Back-pressure: three back-to-back instructions with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADD;  in_pc = 32'h500;
        step();
        check("st1_valid", out_valid, 1);
        check("st1_pc", out_pc, 32'h500);
        check("st1_in_ready", in_ready, 1);
        in_instr = I_ADDI; in_pc = 32'h504;
        step();
        check("st2_in_ready", in_ready, 0);
        check("st2_pc", out_pc, 32'h500);
        check("st2_rd", out_rd, 10);
        in_instr = I_JAL;  in_pc = 32'h508;
        step();
        check("st3_in_ready", in_ready, 0);
        check("st3_pc", out_pc, 32'h500);
        check("st3_class", out_class, 0);
        out_ready = 1'b1;
        step();
        check("st4_pc", out_pc, 32'h504);
        check("st4_class", out_class, 1);
        check("st4_in_ready", in_ready, 1);
        step();
        check("st5_valid", out_valid, 1);
        check("st5_pc", out_pc, 32'h508);
        check("st5_class", out_class, 5);
        in_valid = 1'b0;
        step();
        check("st6_valid", out_valid, 0);
        check("st6_ill_cnt", ill_count, 5);

        // Flush with one entry held: concurrent illegal is discarded but counted
        out_ready = 1'b0;
        send(I_ADD, 32'h600);
        check("fl1_valid", out_valid, 1);
        in_valid = 1'b1;
        in_instr = 32'h0400_0000; in_pc = 32'h604;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_out_valid", out_valid, 0);
        check("fl1_in_ready", in_ready, 1);
        check("fl1_ill_cnt", ill_count, 6);
        check("fl1_ill_alt", b_ill_count, 3);

        // Flush with both entries full and fetch still offering
        in_valid = 1'b1;
        in_instr = I_ADD;  in_pc = 32'h700;
        step();
        in_instr = I_ADDI; in_pc = 32'h704;
        step();
        check("fl2_full", in_ready, 0);
        in_instr = 32'hFC00_0000; in_pc = 32'h708;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_out_valid", out_valid, 0);
        check("fl2_in_ready", in_ready, 1);
        check("fl2_ill_cnt", ill_count, 6);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl2_quiet", out_valid, 0);
        end

        // Reset in the middle of a stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADD;  in_pc = 32'h800;
        step();
        in_instr = I_ADDI; in_pc = 32'h804;
        step();
        check("rs_full", in_ready, 0);
        in_instr = 32'hFC00_0000; in_pc = 32'h808;
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rs_out_valid", out_valid, 0);
        check("rs_in_ready", in_ready, 1);
        check("rs_ill_cnt", ill_count, 0);
        check("rs_ill_alt", b_ill_count, 0);
        check("rs_pc", out_pc, 0);
        check("rs_imm", out_imm_ext, 0);
        step();
        check("rs_quiet", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
